// File: rtl/fll_cfg_ctrl.sv
// FLL config-port sequencer: optional boot writes, lock wait with timeout, then round-robin sharing between SoC (0) and debug (1).
// 3 cycles per transaction with a zero-wait FLL; requesters hold req until ack. Lock-loss pulse built only with `FLL_CFG_LOCK_IRQ_EN.
module fll_cfg_ctrl #(
    parameter logic [31:0] BOOT_CFG0    = 32'h0000_0000,
    parameter logic [31:0] BOOT_CFG1    = 32'h0000_0000,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_en_i,
    input  logic        req0_i,
    input  logic        wrn0_i,
    input  logic [1:0]  add0_i,
    input  logic [31:0] wdata0_i,
    input  logic        req1_i,
    input  logic        wrn1_i,
    input  logic [1:0]  add1_i,
    input  logic [31:0] wdata1_i,
    output logic        ack0_o,
    output logic [31:0] rdata0_o,
    output logic        ack1_o,
    output logic [31:0] rdata1_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_r_data_i,
    input  logic        fll_lock_i,
    output logic        lock_o,
    output logic        boot_done_o,
    output logic        lock_timeout_o,
    output logic        busy_o,
    output logic        lock_lost_o
);

    localparam int unsigned      CNT_W    = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_BOOT0     = 3'd1;
    localparam logic [2:0] ST_BOOT1     = 3'd2;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd3;
    localparam logic [2:0] ST_IDLE      = 3'd4;
    localparam logic [2:0] ST_XFER      = 3'd5;
    localparam logic [2:0] ST_RESP      = 3'd6;

    logic [2:0]       state_q;
    logic [2:0]       state_nxt;
    logic             req_q;
    logic             wrn_q;
    logic [1:0]       add_q;
    logic [31:0]      data_q;
    logic             gnt_q;
    logic             rr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             tmo_q;
    logic             busy_q;
    logic [31:0]      rdata0_q;
    logic [31:0]      rdata1_q;
    logic             lock_meta;
    logic             lock_q;

    logic ack_seen;
    logic grant_vld;
    logic grant_sel;

    // The FLL ack only counts while our request is actually up.
    assign ack_seen  = req_q & fll_ack_i;
    assign grant_vld = done_q & (req0_i | req1_i);
    assign grant_sel = (req0_i & req1_i) ? rr_q : req1_i;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_START:     state_nxt = boot_en_i ? ST_BOOT0 : ST_IDLE;
            ST_BOOT0:     if (ack_seen) state_nxt = ST_BOOT1;
            ST_BOOT1:     if (ack_seen) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (lock_q || cnt_q == CNT_LAST) state_nxt = ST_IDLE;
            ST_IDLE:      if (grant_vld) state_nxt = ST_XFER;
            ST_XFER:      if (ack_seen) state_nxt = ST_RESP;
            ST_RESP:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_START;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_meta <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            lock_meta <= fll_lock_i;
            lock_q    <= lock_meta;
        end
    end

    // BOOT1 is entered with req low, which gives the mandatory gap cycle after BOOT0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q  <= 1'b0;
            wrn_q  <= 1'b0;
            add_q  <= 2'd0;
            data_q <= 32'd0;
            gnt_q  <= 1'b0;
            rr_q   <= 1'b0;
        end else if (state_q == ST_START && boot_en_i) begin
            req_q  <= 1'b1;
            wrn_q  <= 1'b0;
            add_q  <= 2'd0;
            data_q <= BOOT_CFG0;
        end else if (state_q == ST_BOOT1 && !req_q) begin
            req_q  <= 1'b1;
            wrn_q  <= 1'b0;
            add_q  <= 2'd1;
            data_q <= BOOT_CFG1;
        end else if (state_q == ST_IDLE && grant_vld) begin
            req_q  <= 1'b1;
            gnt_q  <= grant_sel;
            wrn_q  <= grant_sel ? wrn1_i   : wrn0_i;
            add_q  <= grant_sel ? add1_i   : add0_i;
            data_q <= grant_sel ? wdata1_i : wdata0_i;
            if (req0_i && req1_i) begin
                rr_q <= ~grant_sel;
            end
        end else if (ack_seen) begin
            req_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else if (state_q == ST_XFER && ack_seen && wrn_q) begin
            if (gnt_q) begin
                rdata1_q <= fll_r_data_i;
            end else begin
                rdata0_q <= fll_r_data_i;
            end
        end
    end

    // Lock is checked before the timeout so a simultaneous lock never flags a timeout.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else if (state_q == ST_START && !boot_en_i) begin
            done_q <= 1'b1;
        end else if (state_q == ST_WAIT_LOCK) begin
            if (lock_q) begin
                done_q <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                done_q <= 1'b1;
                tmo_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef FLL_CFG_LOCK_IRQ_EN
    logic lock_d;
    logic lost_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_d <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            lock_d <= lock_q;
            lost_q <= done_q & lock_d & ~lock_q;
        end
    end

    assign lock_lost_o = lost_q;
`else
    assign lock_lost_o = 1'b0;
`endif

    assign ack0_o         = (state_q == ST_RESP) & ~gnt_q;
    assign ack1_o         = (state_q == ST_RESP) &  gnt_q;
    assign rdata0_o       = rdata0_q;
    assign rdata1_o       = rdata1_q;
    assign fll_req_o      = req_q;
    assign fll_wrn_o      = wrn_q;
    assign fll_add_o      = add_q;
    assign fll_data_o     = data_q;
    assign lock_o         = lock_q;
    assign boot_done_o    = done_q;
    assign lock_timeout_o = tmo_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Directed bench for fll_cfg_ctrl: boot with lock, boot timeout, read path, arbitration, boot stall, reset abort, lock loss.
module tb_fll_cfg_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_en = 1'b0;
    logic        req0 = 1'b0, wrn0 = 1'b0, req1 = 1'b0, wrn1 = 1'b0;
    logic [1:0]  add0 = 2'd0, add1 = 2'd0;
    logic [31:0] wdata0 = 32'd0, wdata1 = 32'd0;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic        fll_req, fll_wrn, fll_ack;
    logic [1:0]  fll_add;
    logic [31:0] fll_data;
    logic [31:0] fll_r_data = 32'd0;
    logic        fll_lock = 1'b0;
    logic        lock, boot_done, lock_timeout, busy, lock_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_dly  = 0;
    int hi_cnt;
    int cyc = 0;

    int          req_hi_cycles = 0;
    int          ack0_cnt = 0, ack1_cnt = 0, dual_ack = 0;
    int          order[$];
    logic [1:0]  txn_add[$];
    logic [31:0] txn_dat[$];
    logic        txn_wrn[$];
    int          txn_cyc[$];

`ifdef FLL_CFG_LOCK_IRQ_EN
    localparam logic EXP_LOST = 1'b1;
`else
    localparam logic EXP_LOST = 1'b0;
`endif

    fll_cfg_ctrl #(
        .BOOT_CFG0   (32'h1234_5678),
        .BOOT_CFG1   (32'h0000_00AB),
        .LOCK_TIMEOUT(16)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .boot_en_i     (boot_en),
        .req0_i        (req0),
        .wrn0_i        (wrn0),
        .add0_i        (add0),
        .wdata0_i      (wdata0),
        .req1_i        (req1),
        .wrn1_i        (wrn1),
        .add1_i        (add1),
        .wdata1_i      (wdata1),
        .ack0_o        (ack0),
        .rdata0_o      (rdata0),
        .ack1_o        (ack1),
        .rdata1_o      (rdata1),
        .fll_req_o     (fll_req),
        .fll_wrn_o     (fll_wrn),
        .fll_add_o     (fll_add),
        .fll_data_o    (fll_data),
        .fll_ack_i     (fll_ack),
        .fll_r_data_i  (fll_r_data),
        .fll_lock_i    (fll_lock),
        .lock_o        (lock),
        .boot_done_o   (boot_done),
        .lock_timeout_o(lock_timeout),
        .busy_o        (busy),
        .lock_lost_o   (lock_lost)
    );

    always #5 clk = ~clk;

    // FLL model: ack (combinational) once req has been high for ack_dly full cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hi_cnt <= 0;
        else        hi_cnt <= fll_req ? hi_cnt + 1 : 0;
    end
    assign fll_ack = fll_req && (hi_cnt >= ack_dly);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fll_req) req_hi_cycles++;
        if (fll_req && fll_ack) begin
            txn_add.push_back(fll_add);
            txn_dat.push_back(fll_data);
            txn_wrn.push_back(fll_wrn);
            txn_cyc.push_back(cyc);
        end
        if (ack0) begin ack0_cnt++; order.push_back(0); end
        if (ack1) begin ack1_cnt++; order.push_back(1); end
        if (ack0 && ack1) dual_ack++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b, a0, hb, ob, o0, o1;

    initial begin
        // ---------------- boot with lock, stall during boot, lock loss ----------------
        boot_en = 1'b1;
        tick(2);
        check("rst_fll_req", fll_req, 0);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_boot_done", boot_done, 0);
        check("rst_timeout", lock_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_lock", lock, 0);
        check("rst_lock_lost", lock_lost, 0);
        check("rst_fll_data", fll_data, 0);
        check("rst_rdata0", rdata0, 0);
        b = txn_add.size();
        rst_n = 1'b1;
        tick(1);
        check("boot0_req", fll_req, 1);
        check("boot0_add", fll_add, 0);
        check("boot0_data", fll_data, 32'h1234_5678);
        check("boot0_busy", busy, 1);
        tick(1);
        check("boot_gap", fll_req, 0);
        tick(3);
        req1 = 1'b1; wrn1 = 1'b0; add1 = 2'd3; wdata1 = 32'hCAFE_0001;
        tick(5);
        fll_lock = 1'b1;
        tick(2);
        check("wait_done", boot_done, 0);
        check("wait_lock_sync", lock, 1);
        check("stall_no_req", fll_req, 0);
        tick(1);
        check("lock_done", boot_done, 1);
        check("lock_no_timeout", lock_timeout, 0);
        check("lock_idle_busy", busy, 0);
        check("stall_req_low", fll_req, 0);
        check("boot_txn_cnt", txn_add.size() - b, 2);
        check("boot_txn0_add", txn_add[b], 0);
        check("boot_txn0_dat", txn_dat[b], 32'h1234_5678);
        check("boot_txn0_wrn", txn_wrn[b], 0);
        check("boot_txn1_add", txn_add[b+1], 1);
        check("boot_txn1_dat", txn_dat[b+1], 32'h0000_00AB);
        check("boot_gap_cycles", txn_cyc[b+1] - txn_cyc[b], 2);
        tick(1);
        check("stall_grant_req", fll_req, 1);
        check("stall_grant_add", fll_add, 3);
        tick(1);
        check("stall_ack1", ack1, 1);
        check("stall_ack0", ack0, 0);
        req1 = 1'b0;
        check("stall_txn_dat", txn_dat[b+2], 32'hCAFE_0001);
        tick(1);
        check("stall_ack1_off", ack1, 0);
        tick(4);
        fll_lock = 1'b0;
        tick(2);
        check("loss_lock_o", lock, 0);
        check("loss_pre", lock_lost, 0);
        tick(1);
        check("loss_pulse", lock_lost, EXP_LOST);
        tick(1);
        check("loss_post", lock_lost, 0);
        check("loss_done_kept", boot_done, 1);
        check("loss_no_timeout", lock_timeout, 0);

        // ---------------- boot timeout, then port-0 write ----------------
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(19);
        check("tmo_not_yet", boot_done, 0);
        check("tmo_busy", busy, 1);
        tick(1);
        check("tmo_done", boot_done, 1);
        check("tmo_flag", lock_timeout, 1);
        check("tmo_idle", busy, 0);
        b = txn_add.size();
        req0 = 1'b1; wrn0 = 1'b0; add0 = 2'd0; wdata0 = 32'h0000_0077;
        tick(2);
        check("tmo_wr_ack0", ack0, 1);
        req0 = 1'b0;
        check("tmo_wr_dat", txn_dat[b], 32'h0000_0077);
        fll_lock = 1'b1;
        tick(4);
        check("late_lock", lock, 1);
        check("late_tmo_kept", lock_timeout, 1);

        // ---------------- arbitration, both held ----------------
        ob = order.size(); o0 = ack0_cnt; o1 = ack1_cnt;
        wdata0 = 32'h0000_00A0; wdata1 = 32'h0000_00B1; add1 = 2'd1; wrn1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 100 && order.size() < ob + 8; i++) @(negedge clk);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        check("arb_count", order.size() - ob, 8);
        for (int i = 0; i < 8 && ob + i < order.size(); i++)
            check($sformatf("arb_order%0d", i), order[ob+i], i % 2);
        check("arb_dual_ack", dual_ack, 0);
        check("arb_ack0_cnt", ack0_cnt - o0, 4);
        check("arb_ack1_cnt", ack1_cnt - o1, 4);

        // ---------------- read path, delayed ack ----------------
        rst_n = 1'b0; boot_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("nb_done", boot_done, 1);
        check("nb_busy", busy, 0);
        check("nb_timeout", lock_timeout, 0);
        ack_dly = 4; fll_r_data = 32'hDEAD_BEEF;
        req0 = 1'b1; wrn0 = 1'b1; add0 = 2'd2;
        hb = req_hi_cycles;
        tick(1);
        check("rd_req", fll_req, 1);
        check("rd_wrn", fll_wrn, 1);
        check("rd_add", fll_add, 2);
        tick(4);
        check("rd_wait_ack0", ack0, 0);
        check("rd_wait_req", fll_req, 1);
        tick(1);
        check("rd_ack0", ack0, 1);
        check("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        check("rd_ack1", ack1, 0);
        check("rd_rdata1", rdata1, 0);
        check("rd_req_drop", fll_req, 0);
        check("rd_req_cycles", req_hi_cycles - hb, 5);
        req0 = 1'b0;
        tick(1);
        check("rd_ack0_off", ack0, 0);
        ack_dly = 0; fll_r_data = 32'h1111_1111;
        req0 = 1'b1; wrn0 = 1'b0; add0 = 2'd1; wdata0 = 32'h0000_0055;
        tick(2);
        check("wr_ack0", ack0, 1);
        check("wr_rdata0_kept", rdata0, 32'hDEAD_BEEF);
        req0 = 1'b0;

        // ---------------- reset during XFER ----------------
        tick(1);
        ack_dly = 10;
        req0 = 1'b1; wrn0 = 1'b0; add0 = 2'd3; wdata0 = 32'h0000_0099;
        a0 = ack0_cnt;
        tick(1);
        check("abort_req_up", fll_req, 1);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("abort_req_drop", fll_req, 0);
        check("abort_ack0", ack0, 0);
        req0 = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("abort_no_ack", ack0_cnt - a0, 0);
        check("abort_done", boot_done, 1);
        check("abort_idle_req", fll_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
